freq_setpoint: RTL and testbench

FREQ_SETPOINT -- requirements
Module: freq_setpoint

---
 rtl/freq_setpoint.sv | 99 +++++++++
 tb/tb_freq_setpoint.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/freq_setpoint.sv
// Frequency setpoint register driven by quadrature up/down pulses.
// Consecutive same-direction events inside FAST_WINDOW cycles step by
// FAST_STEP, otherwise by 1. The result is clamped to [MIN_VAL, MAX_VAL]
// and offered downstream on a valid/ready port where the latest value wins.
module freq_setpoint #(
  parameter int WIDTH       = 16,
  parameter int MIN_VAL     = 2,
  parameter int MAX_VAL     = 50000,
  parameter int INIT_VAL    = 1000,
  parameter int FAST_WINDOW = 250000,
  parameter int WIN_W       = 20,
  parameter int FAST_STEP   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             at_min,
  output logic             at_max
);

  localparam int WP1 = WIDTH + 1;

  localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT_VAL);
  localparam logic [WIN_W-1:0] WIN_MAX   = WIN_W'(FAST_WINDOW);
  localparam logic [WIDTH:0]   STEP_FAST = WP1'(FAST_STEP);
  localparam logic [WIDTH:0]   STEP_ONE  = WP1'(1);

  // Upward step with one extra bit of headroom so the sum cannot wrap.
  function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] v,
                                              input logic [WIDTH:0]   s);
    logic [WIDTH:0] sum;
    sum = {1'b0, v} + s;
    if (sum > {1'b0, MAX_V}) return MAX_V;
    return sum[WIDTH-1:0];
  endfunction

  // Downward step in signed arithmetic so a borrow below zero shows as negative.
  function automatic logic [WIDTH-1:0] sat_dn(input logic [WIDTH-1:0] v,
                                              input logic [WIDTH:0]   s);
    logic signed [WIDTH+1:0] diff;
    diff = $signed({2'b00, v}) - $signed({1'b0, s});
    if (diff < $signed({2'b00, MIN_V})) return MIN_V;
    return diff[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] sp_next;
  logic [WIN_W-1:0] gap_q;
  logic             last_up_q;
  logic             ev;
  logic             ev_up;
  logic             fast;
  logic [WIDTH:0]   step;
  logic             changed;

  // Event decode, step selection and clamped next setpoint.
  always_comb begin
    ev      = up ^ down;
    ev_up   = up & ~down;
    fast    = (ev_up == last_up_q) && (gap_q < WIN_MAX);
    step    = fast ? STEP_FAST : STEP_ONE;
    sp_next = sp_q;
    if (ev) sp_next = ev_up ? sat_up(sp_q, step) : sat_dn(sp_q, step);
    changed = ev && (sp_next != sp_q);
  end

  // Setpoint, limit flags, gap counter, direction memory and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q      <= INIT_V;
      at_min    <= (INIT_V == MIN_V);
      at_max    <= (INIT_V == MAX_V);
      out_valid <= 1'b1;
      gap_q     <= WIN_MAX;
      last_up_q <= 1'b1;
    end else begin
      if (ev) begin
        gap_q     <= '0;
        last_up_q <= ev_up;
      end else if (gap_q < WIN_MAX) begin
        gap_q <= gap_q + WIN_W'(1);
      end
      sp_q   <= sp_next;
      at_min <= (sp_next == MIN_V);
      at_max <= (sp_next == MAX_V);
      if (changed)        out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  assign out_data = sp_q;

endmodule

// File: tb/tb_freq_setpoint.sv
// Randomized and directed bench for freq_setpoint with a behavioural model
// and a transfer scoreboard.
module tb_freq_setpoint;

  localparam int WIDTH = 16;
  localparam int MINV  = 2;
  localparam int MAXV  = 50000;
  localparam int INITV = 1000;
  localparam int FW    = 40;
  localparam int FSTEP = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             up = 1'b0;
  logic             down = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             at_min;
  logic             at_max;

  freq_setpoint #(
    .WIDTH(WIDTH), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INITV),
    .FAST_WINDOW(FW), .WIN_W(8), .FAST_STEP(FSTEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // model state as visible on the outputs now
  int m_sp, m_valid, m_last_up, m_have, m_last_edge;
  // model state after the upcoming edge
  int p_sp, p_valid, p_last_up, p_have, p_last_edge;
  int edge_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sp = INITV; m_valid = 1; m_last_up = 1; m_have = 0; m_last_edge = 0;
    p_sp = m_sp; p_valid = m_valid; p_last_up = m_last_up;
    p_have = m_have; p_last_edge = m_last_edge;
  endtask

  // One clock cycle: commit the previous prediction, drive inputs, predict.
  task automatic cycle(input bit u, input bit d, input bit r, input bit rst = 1'b0);
    int step;
    bit fast;
    @(posedge clk);
    #1;
    edge_idx++;
    m_sp = p_sp; m_valid = p_valid; m_last_up = p_last_up;
    m_have = p_have; m_last_edge = p_last_edge;
    if (rst) begin
      rst_n = 1'b0; up = 1'b0; down = 1'b0; out_ready = 1'b0;
      model_reset();
      return;
    end
    rst_n = 1'b1; up = u; down = d; out_ready = r;
    if (m_valid != 0 && r) exp_q.push_back(m_sp);
    p_valid = (m_valid != 0 && r) ? 0 : m_valid;
    if (u != d) begin
      fast = m_have != 0 && (m_last_up == int'(u)) && (edge_idx - m_last_edge - 1 < FW);
      step = fast ? FSTEP : 1;
      if (u) p_sp = (m_sp + step > MAXV) ? MAXV : m_sp + step;
      else   p_sp = (m_sp - step < MINV) ? MINV : m_sp - step;
      if (p_sp != m_sp) p_valid = 1;
      p_last_up = int'(u); p_have = 1; p_last_edge = edge_idx;
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, r);
  endtask

  // Monitor: compare visible state each cycle and score every transfer.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      chk("out_data", int'(out_data), m_sp);
      chk("out_valid", int'(out_valid), m_valid);
      chk("at_min", int'(at_min), int'(m_sp == MINV));
      chk("at_max", int'(at_max), int'(m_sp == MAXV));
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", int'(out_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_data", int'(out_data), e);
        end
      end
    end
  end

  initial begin
    model_reset();
    cycle(0, 0, 0, 1'b1);
    cycle(0, 0, 0, 1'b1);
    // reset value handed over once
    cycle(0, 0, 1);
    idle(2, 1);
    // slow first up, then fast ups, then a reversal
    cycle(1, 0, 1); idle(20, 1);
    cycle(1, 0, 1); idle(20, 1);
    cycle(1, 0, 1); idle(10, 1);
    cycle(0, 1, 1); idle(3, 1);
    // ups beyond the window step by one; simultaneous up/down is ignored
    idle(60, 1); cycle(1, 0, 1);
    idle(60, 1); cycle(1, 0, 1);
    idle(5, 1);  cycle(1, 1, 1); idle(3, 1);
    // walk down to 3, then two downs against the lower limit
    while (p_sp > 3) begin
      if (p_sp - 3 >= FSTEP) cycle(0, 1, 1);
      else begin idle(FW + 5, 1); cycle(0, 1, 1); end
    end
    idle(FW + 5, 1);
    cycle(0, 1, 1); cycle(0, 1, 1); idle(3, 1);
    // walk up to 49995, then fast ups against the upper limit
    cycle(1, 0, 1);
    while (p_sp < 49995) begin
      if (49995 - p_sp >= FSTEP) cycle(1, 0, 1);
      else begin idle(FW + 5, 1); cycle(1, 0, 1); end
    end
    cycle(1, 0, 1); cycle(1, 0, 1); idle(3, 1);
    // stalled consumer: latest value wins, ready rises with a new event
    cycle(0, 1, 1); idle(FW + 5, 1);
    for (int i = 0; i < 5; i++) begin cycle(0, 1, 0); idle(2, 0); end
    cycle(0, 1, 1); idle(3, 1);
    // reset in the middle of a burst with a pending value
    cycle(0, 1, 0); cycle(0, 1, 0);
    cycle(0, 0, 0, 1'b1);
    cycle(0, 1, 0); idle(2, 0); idle(2, 1);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) cycle(0, 0, 0, 1'b1);
      else if (r < 5) idle($urandom_range(35, 60), 1'($urandom_range(0, 1)));
      else cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) != 0));
    end
    idle(3, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
